// File: rtl/id_ex_skid_buf.sv
// id_ex_skid_buf: decode-to-execute pipeline buffer with valid/ready handshake and a two-entry skid store
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   i_valid / o_ready            upstream handshake (o_ready depends on registered state and rst only)
//   o_valid / i_ready            downstream handshake
//   i_flush                      squashes every held beat and any beat offered in the same cycle
//   i_WB .. i_read_data2         incoming payload
//   o_WB .. o_read_data2         head-entry payload; control groups read as zero while empty
//   o_stall_cnt                  saturating count of cycles with o_valid && !i_ready
module id_ex_skid_buf #(
    parameter int WbSize  = 4,
    parameter int MemSize = 6,
    parameter int ExSize  = 3,
    parameter int PcW     = 32,
    parameter int RegW    = 3,
    parameter int DataW   = 16,
    parameter int CntW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    input  logic [WbSize-1:0]  i_WB,
    input  logic [MemSize-1:0] i_Mem,
    input  logic [ExSize-1:0]  i_Ex,
    input  logic               i_chg_flag,
    input  logic [PcW-1:0]     i_pc,
    input  logic [RegW-1:0]    i_Rsrc1,
    input  logic [RegW-1:0]    i_Rsrc2,
    input  logic [RegW-1:0]    i_Rdst,
    input  logic [DataW-1:0]   i_immd,
    input  logic [DataW-1:0]   i_read_data1,
    input  logic [DataW-1:0]   i_read_data2,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WbSize-1:0]  o_WB,
    output logic [MemSize-1:0] o_Mem,
    output logic [ExSize-1:0]  o_Ex,
    output logic               o_chg_flag,
    output logic [PcW-1:0]     o_pc,
    output logic [RegW-1:0]    o_Rsrc1,
    output logic [RegW-1:0]    o_Rsrc2,
    output logic [RegW-1:0]    o_Rdst,
    output logic [DataW-1:0]   o_immd,
    output logic [DataW-1:0]   o_read_data1,
    output logic [DataW-1:0]   o_read_data2,
    output logic [CntW-1:0]    o_stall_cnt
);
    localparam int CtlW = WbSize + MemSize + ExSize + 1;
    localparam int PlW  = CtlW + PcW + 3 * RegW + 3 * DataW;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nx;
    logic [PlW-1:0] main_q, skid_q, in_pl;
    logic [CntW-1:0] stall_cnt;
    logic acc, rel, ld_main_in, ld_main_skid, ld_skid;
    assign in_pl = {i_WB, i_Mem, i_Ex, i_chg_flag, i_pc, i_Rsrc1, i_Rsrc2, i_Rdst,
                    i_immd, i_read_data1, i_read_data2};
    assign o_ready = (state != FULL) && !rst;
    assign o_valid = state != EMPTY;
    assign acc = i_valid && o_ready;
    assign rel = o_valid && i_ready;
    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                state_nx   = acc ? ONE : EMPTY;
                ld_main_in = acc;
            end
            ONE: begin
                state_nx   = (acc && !rel) ? FULL : (rel && !acc) ? EMPTY : ONE;
                ld_main_in = acc && rel;
                ld_skid    = acc && !rel;
            end
            FULL: begin
                state_nx     = rel ? ONE : FULL;
                ld_main_skid = rel;
            end
            default: state_nx = EMPTY;
        endcase
        // A flush drops everything, including a beat accepted this cycle; leaving main untouched keeps the data fields at their last values.
        if (i_flush) begin
            state_nx     = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (ld_main_in)
                main_q <= in_pl;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= in_pl;
            if (o_valid && !i_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CntW'(1);
        end
    end
    // Control groups become a bubble when no beat is held; data fields are passed through unchanged.
    assign {o_WB, o_Mem, o_Ex, o_chg_flag} = o_valid ? main_q[PlW-1 -: CtlW] : '0;
    assign {o_pc, o_Rsrc1, o_Rsrc2, o_Rdst, o_immd, o_read_data1, o_read_data2} = main_q[PlW-CtlW-1:0];
    assign o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_id_ex_skid_buf.sv
// tb_id_ex_skid_buf: randomized and directed checks of id_ex_skid_buf against a queue-based model
module tb_id_ex_skid_buf;
    localparam int PW = 103;
    localparam int CW = 14;
    logic clk = 1'b0;
    logic rst, i_valid, i_ready, i_flush;
    logic [PW-1:0] in_pl;
    logic [3:0] i_WB;
    logic [5:0] i_Mem;
    logic [2:0] i_Ex;
    logic i_chg_flag;
    logic [31:0] i_pc;
    logic [2:0] i_Rsrc1, i_Rsrc2, i_Rdst;
    logic [15:0] i_immd, i_read_data1, i_read_data2;
    logic o_ready, o_valid, o_chg_flag;
    logic [3:0] o_WB;
    logic [5:0] o_Mem;
    logic [2:0] o_Ex;
    logic [31:0] o_pc;
    logic [2:0] o_Rsrc1, o_Rsrc2, o_Rdst;
    logic [15:0] o_immd, o_read_data1, o_read_data2;
    logic [7:0] o_stall_cnt;
    logic s_ready, s_valid, s_chg_flag;
    logic [3:0] s_WB;
    logic [5:0] s_Mem;
    logic [2:0] s_Ex;
    logic [31:0] s_pc;
    logic [2:0] s_Rsrc1, s_Rsrc2, s_Rdst;
    logic [15:0] s_immd, s_read_data1, s_read_data2;
    logic [1:0] s_stall_cnt;
    logic [PW-1:0] out_pl;
    int n_checks = 0;
    int n_fail = 0;
    logic [PW-1:0] mq[$];
    logic [PW-1:0] last;
    int stall, stall2;

    assign {i_WB, i_Mem, i_Ex, i_chg_flag, i_pc, i_Rsrc1, i_Rsrc2, i_Rdst, i_immd, i_read_data1, i_read_data2} = in_pl;
    assign out_pl = {o_WB, o_Mem, o_Ex, o_chg_flag, o_pc, o_Rsrc1, o_Rsrc2, o_Rdst, o_immd, o_read_data1, o_read_data2};

    always #5 clk = ~clk;

    id_ex_skid_buf dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_WB(i_WB), .i_Mem(i_Mem), .i_Ex(i_Ex), .i_chg_flag(i_chg_flag), .i_pc(i_pc),
        .i_Rsrc1(i_Rsrc1), .i_Rsrc2(i_Rsrc2), .i_Rdst(i_Rdst), .i_immd(i_immd),
        .i_read_data1(i_read_data1), .i_read_data2(i_read_data2), .o_valid(o_valid), .i_ready(i_ready),
        .o_WB(o_WB), .o_Mem(o_Mem), .o_Ex(o_Ex), .o_chg_flag(o_chg_flag), .o_pc(o_pc),
        .o_Rsrc1(o_Rsrc1), .o_Rsrc2(o_Rsrc2), .o_Rdst(o_Rdst), .o_immd(o_immd),
        .o_read_data1(o_read_data1), .o_read_data2(o_read_data2), .o_stall_cnt(o_stall_cnt)
    );

    id_ex_skid_buf #(.CntW(2)) u_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_flush(i_flush),
        .i_WB(i_WB), .i_Mem(i_Mem), .i_Ex(i_Ex), .i_chg_flag(i_chg_flag), .i_pc(i_pc),
        .i_Rsrc1(i_Rsrc1), .i_Rsrc2(i_Rsrc2), .i_Rdst(i_Rdst), .i_immd(i_immd),
        .i_read_data1(i_read_data1), .i_read_data2(i_read_data2), .o_valid(s_valid), .i_ready(i_ready),
        .o_WB(s_WB), .o_Mem(s_Mem), .o_Ex(s_Ex), .o_chg_flag(s_chg_flag), .o_pc(s_pc),
        .o_Rsrc1(s_Rsrc1), .o_Rsrc2(s_Rsrc2), .o_Rdst(s_Rdst), .o_immd(s_immd),
        .o_read_data1(s_read_data1), .o_read_data2(s_read_data2), .o_stall_cnt(s_stall_cnt)
    );

    function automatic logic [PW-1:0] beat(input logic [31:0] pc);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = 1'($urandom_range(0, 1));
        b[PW-CW-1 -: 32] = pc;
        return b;
    endfunction

    function automatic logic [PW-1:0] exp_pl();
        return (mq.size() > 0) ? mq[0] : {{CW{1'b0}}, last[PW-CW-1:0]};
    endfunction

    // Reference model: an in-order FIFO of capacity two, advanced once per clock edge.
    task automatic tick();
        int sz;
        bit acc, rel;
        sz  = mq.size();
        acc = i_valid && sz < 2 && !rst;
        rel = sz > 0 && i_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            last = '0;
            stall = 0;
            stall2 = 0;
        end else begin
            if (sz > 0 && !i_ready) begin
                if (stall < 255) stall++;
                if (stall2 < 3) stall2++;
            end
            if (i_flush) mq.delete();
            else begin
                if (rel) void'(mq.pop_front());
                if (acc) mq.push_back(in_pl);
            end
            if (mq.size() > 0) last = mq[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; i_valid = 0; i_ready = 0; i_flush = 0; in_pl = beat(32'h1);
        tick(); tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", o_ready); end
        n_checks++; if (out_pl !== '0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", out_pl); end
        n_checks++; if (o_stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", o_stall_cnt); end
        rst = 0;
        tick();
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_stream();
        i_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_pl = beat(32'h10 + i); i_valid = 1;
            n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b exp 1", i, o_ready); end
            tick();
            n_checks++; if (o_pc !== 32'h10 + i) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, o_pc, 32'h10 + i); end
            n_checks++; if (out_pl !== exp_pl() || o_valid !== 1'b1) begin n_fail++; $display("FAIL stream_payload[%0d] got %h/%b exp %h/1", i, out_pl, o_valid, exp_pl()); end
            n_checks++; if (o_stall_cnt !== 8'd0) begin n_fail++; $display("FAIL stream_stall[%0d] got %0d exp 0", i, o_stall_cnt); end
        end
        i_valid = 0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] seq[3];
        seq = '{32'h20, 32'h21, 32'h22};
        i_ready = 0; i_valid = 1;
        in_pl = beat(32'h20); tick();
        in_pl = beat(32'h21); tick();
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop got %b exp 0", o_ready); end
        in_pl = beat(32'h22); tick(); tick();
        n_checks++; if (o_pc !== 32'h20 || out_pl !== exp_pl()) begin n_fail++; $display("FAIL bp_hold got %h exp %h", out_pl, exp_pl()); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b exp 0", o_ready); end
        n_checks++; if (o_stall_cnt !== 8'd3) begin n_fail++; $display("FAIL bp_stall got %0d exp 3", o_stall_cnt); end
        i_ready = 1;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_checks++; if (o_pc !== seq[i] || out_pl !== exp_pl()) begin n_fail++; $display("FAIL bp_order[%0d] got %h exp pc %h", i, o_pc, seq[i]); end
        end
        i_valid = 0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b exp 0", o_valid); end
        n_checks++; if (o_stall_cnt !== 8'd3) begin n_fail++; $display("FAIL bp_stall_final got %0d exp 3", o_stall_cnt); end
    endtask

    task automatic test_flush_full();
        logic [PW-1:0] b;
        int s;
        i_ready = 0; i_valid = 1;
        b = beat(32'h28); b[PW-1 -: 4] = 4'hF; in_pl = b; tick();
        b = beat(32'h29); b[PW-1 -: 4] = 4'hF; in_pl = b; tick();
        n_checks++; if (o_WB !== 4'hF || o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_setup got wb %h ready %b exp F 0", o_WB, o_ready); end
        s = stall;
        i_valid = 0; i_ready = 1; i_flush = 1;
        tick();
        i_flush = 0;
        n_checks++; if (o_valid !== 1'b0 || o_WB !== 4'h0) begin n_fail++; $display("FAIL flush_full got valid %b wb %h exp 0 0", o_valid, o_WB); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready got %b exp 1", o_ready); end
        n_checks++; if (o_stall_cnt !== 8'(s)) begin n_fail++; $display("FAIL flush_full_stall got %0d exp %0d", o_stall_cnt, s); end
        n_checks++; if (out_pl !== exp_pl()) begin n_fail++; $display("FAIL flush_full_payload got %h exp %h", out_pl, exp_pl()); end
    endtask

    task automatic test_flush_accept();
        i_ready = 1; i_valid = 1; in_pl = beat(32'h30); i_flush = 1;
        tick();
        i_flush = 0; i_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (o_valid !== 1'b0 || o_pc === 32'h30) begin n_fail++; $display("FAIL flush_accept[%0d] got valid %b pc %h exp 0 not 30", i, o_valid, o_pc); end
            tick();
        end
    endtask

    task automatic test_saturate();
        rst = 1; tick(); rst = 0;
        i_ready = 0; i_valid = 1; in_pl = beat(32'h40); tick();
        i_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++; if (s_stall_cnt !== 2'(k < 3 ? k : 3)) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, s_stall_cnt, (k < 3 ? k : 3)); end
            n_checks++; if (o_stall_cnt !== 8'(k)) begin n_fail++; $display("FAIL wide_cnt[%0d] got %0d exp %0d", k, o_stall_cnt, k); end
        end
    endtask

    task automatic test_reset_full();
        rst = 1; tick(); rst = 0;
        i_ready = 0; i_valid = 1;
        in_pl = beat(32'h50); tick();
        in_pl = beat(32'h51); tick();
        i_valid = 0;
        repeat (4) tick();
        n_checks++; if (o_stall_cnt !== 8'd5 || o_ready !== 1'b0) begin n_fail++; $display("FAIL rstfull_setup got cnt %0d ready %b exp 5 0", o_stall_cnt, o_ready); end
        rst = 1; tick();
        n_checks++; if (out_pl !== '0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_clear got %h valid %b exp 0", out_pl, o_valid); end
        n_checks++; if (o_ready !== 1'b0 || o_stall_cnt !== 8'd0) begin n_fail++; $display("FAIL rstfull_ready got ready %b cnt %0d exp 0 0", o_ready, o_stall_cnt); end
        rst = 0; #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_after got %b exp 1", o_ready); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_empty got %b exp 0", o_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst     = ($urandom % 100) == 0;
            i_flush = ($urandom % 20) == 0;
            i_valid = ($urandom % 4) != 0;
            i_ready = ($urandom % 3) != 0;
            in_pl   = beat($urandom);
            tick();
            n_checks++;
            if (out_pl !== exp_pl() || o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2 && !rst)
                || o_stall_cnt !== 8'(stall) || s_stall_cnt !== 2'(stall2)) begin
                n_fail++;
                $display("FAIL random[%0d] got %h v%b r%b c%0d s%0d exp %h v%b r%b c%0d s%0d", c, out_pl, o_valid, o_ready,
                         o_stall_cnt, s_stall_cnt, exp_pl(), mq.size() > 0, mq.size() < 2 && !rst, stall, stall2);
            end
        end
        rst = 0; i_flush = 0; i_valid = 0;
    endtask

    initial begin
        mq.delete(); last = '0; stall = 0; stall2 = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_accept();
        test_saturate();
        test_reset_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_skid_buf.md
# id_ex_skid_buf

Parametrised decode-to-execute pipeline buffer with a valid/ready handshake, a two-entry skid store, synchronous flush and bubble insertion. It sits between the decode stage and the ALU stage. It carries the WB/Mem/Ex control groups, change-flag, PC, register addresses, immediate and both read operands. It lets the execute side back-pressure decode without losing an instruction, and it lets the hazard/branch unit squash in-flight instructions.

## Interface
Parameters:
- WbSize, 4, width of write-back control group
- MemSize, 6, width of memory control group
- ExSize, 3, width of execute control group
- PcW, 32, PC width
- RegW, 3, register-address width
- DataW, 16, immediate and operand width
- CntW, 8, stall-counter width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream beat present
- o_ready  out  1  buffer can accept a beat this cycle
- i_flush  in  1  synchronous squash of all held beats
- i_WB, i_Mem, i_Ex  in  WbSize/MemSize/ExSize  control groups
- i_chg_flag  in  1  flag-update enable
- i_pc  in  PcW  instruction PC
- i_Rsrc1, i_Rsrc2, i_Rdst  in  RegW  register addresses
- i_immd, i_read_data1, i_read_data2  in  DataW  immediate and operands
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head this cycle
- o_WB, o_Mem, o_Ex, o_chg_flag, o_pc, o_Rsrc1, o_Rsrc2, o_Rdst, o_immd, o_read_data1, o_read_data2  out  as inputs  head-entry payload
- o_stall_cnt  out  CntW  saturating count of back-pressured cycles

## Operation
- Accept = i_valid && o_ready. Release = o_valid && i_ready.
- Storage has two entries:
  - main: drives the outputs.
  - skid: holds one extra beat.
- State machine:
  - EMPTY: accept → ONE (main ← input).
  - ONE: accept && release → ONE (main ← input). Accept only → FULL (skid ← input). Release only → EMPTY. Neither → ONE (hold).
  - FULL: no accept possible. Release → ONE (main ← skid). Otherwise hold.
- o_ready = (state != FULL) && !rst. It decodes from registered state only, with no combinational path from i_ready.
- o_valid = (state != EMPTY).
- Bubble rule: when o_valid=0, o_WB, o_Mem, o_Ex and o_chg_flag are forced to 0. The data fields (pc, addresses, immd, operands) hold their last values.
- Flush: when i_flush=1 the next state is EMPTY. Both entries are discarded, and a beat accepted in the same cycle is also discarded. Release handshake in that cycle still counts as consumed downstream.
- Priority: rst > i_flush > normal transitions.
- Stall counter: increments on every cycle with o_valid && !i_ready. It saturates at 2^CntW−1. It is cleared only by rst and is unaffected by flush.

## Timing
- Reset (rst high at edge): state EMPTY, all payload registers 0, o_valid 0, o_stall_cnt 0. o_ready is 0 while rst is high and 1 on the first cycle after.
- Latency: a beat accepted at edge k appears on the outputs with o_valid=1 from edge k onward (one register stage).
- Throughput: one beat per cycle while i_ready stays high. The skid entry is never used in that case.
- Back-pressure: with i_ready low, one further beat is absorbed into skid, then o_ready drops. When i_ready rises, the skid beat follows the main beat on the next cycle, in order. There is no reordering and no duplication.
- Payload stays stable while o_valid && !i_ready.
- Reset asserted mid-operation discards both entries in the same edge. A flush asserted while FULL likewise discards both entries in the same edge.
- Counter at max value stays at max and does not wrap.

## Test plan
- Reset, then stream 4 beats (pc 0x10,0x11,0x12,0x13) with i_ready=1 → outputs show 0x10..0x13 on consecutive cycles, o_ready constantly 1, o_stall_cnt=0.
- Hold i_ready=0 and offer pc 0x20,0x21,0x22 → 0x20 and 0x21 are accepted, o_ready=0 from the cycle after 0x21 is accepted, and 0x22 is not accepted. Then raise i_ready → 0x20, 0x21, 0x22 are released in order and o_stall_cnt equals the low cycles with o_valid.
- FULL with i_WB=4'hF beats, then pulse i_flush → next cycle o_valid=0, o_WB=0, o_ready=1, o_stall_cnt unchanged.
- Flush coincident with an accept of pc 0x30 → EMPTY, and 0x30 never appears on the outputs.
- With CntW=2, hold back-pressure for 6 cycles → o_stall_cnt reaches 3 and stays at 3.
- Assert rst while FULL with o_stall_cnt=5 → all outputs 0, o_valid=0, o_ready=0 during reset and 1 after.
